// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with per-register ROB rename tags
// Commit writes values, rename binds ROB tags; reads are combinational with a commit bypass.
module reg_file #(
  parameter int REG_COUNT       = 32,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int ROB_INDEX_WIDTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clr_in,
  input  logic                       rob_to_reg_commit,
  input  logic [ROB_INDEX_WIDTH-1:0] rob_to_reg_rob_index,
  input  logic [REG_INDEX_WIDTH-1:0] rob_to_reg_index,
  input  logic [DATA_WIDTH-1:0]      rob_to_reg_val,
  input  logic                       dc_to_reg_rename,
  input  logic [REG_INDEX_WIDTH-1:0] dc_to_reg_rd,
  input  logic [ROB_INDEX_WIDTH-1:0] dc_to_reg_rob_index,
  input  logic [REG_INDEX_WIDTH-1:0] dc_to_reg_rs1,
  input  logic [REG_INDEX_WIDTH-1:0] dc_to_reg_rs2,
  output logic [DATA_WIDTH-1:0]      reg_to_dc_rs1_val,
  output logic [ROB_INDEX_WIDTH-1:0] reg_to_dc_rs1_rob_index,
  output logic [DATA_WIDTH-1:0]      reg_to_dc_rs2_val,
  output logic [ROB_INDEX_WIDTH-1:0] reg_to_dc_rs2_rob_index
);

  logic [DATA_WIDTH-1:0]      val_q [REG_COUNT];
  logic [DATA_WIDTH-1:0]      val_d [REG_COUNT];
  logic [ROB_INDEX_WIDTH-1:0] tag_q [REG_COUNT];
  logic [ROB_INDEX_WIDTH-1:0] tag_d [REG_COUNT];

  logic commit_ok;
  logic rename_ok;
  logic rs1_byp;
  logic rs2_byp;

  assign commit_ok = rdy_in && rob_to_reg_commit && (rob_to_reg_index != '0);
  assign rename_ok = rdy_in && dc_to_reg_rename && (dc_to_reg_rd != '0) && !clr_in;

  // Rename is applied after the commit tag-clear so it wins on the same register.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (commit_ok) begin
      val_d[rob_to_reg_index] = rob_to_reg_val;
      if (tag_q[rob_to_reg_index] == rob_to_reg_rob_index) begin
        tag_d[rob_to_reg_index] = '0;
      end
    end
    if (rdy_in && clr_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        tag_d[i] = '0;
      end
    end else if (rename_ok) begin
      tag_d[dc_to_reg_rd] = dc_to_reg_rob_index;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  // A commit landing on the producer a reader is waiting for is forwarded in the same cycle.
  assign rs1_byp = rob_to_reg_commit && (dc_to_reg_rs1 != '0) &&
                   (rob_to_reg_index == dc_to_reg_rs1) &&
                   (tag_q[dc_to_reg_rs1] == rob_to_reg_rob_index);
  assign rs2_byp = rob_to_reg_commit && (dc_to_reg_rs2 != '0) &&
                   (rob_to_reg_index == dc_to_reg_rs2) &&
                   (tag_q[dc_to_reg_rs2] == rob_to_reg_rob_index);

  always_comb begin
    reg_to_dc_rs1_val       = val_q[dc_to_reg_rs1];
    reg_to_dc_rs1_rob_index = tag_q[dc_to_reg_rs1];
    if (dc_to_reg_rs1 == '0) begin
      reg_to_dc_rs1_val       = '0;
      reg_to_dc_rs1_rob_index = '0;
    end else if (rs1_byp) begin
      reg_to_dc_rs1_val       = rob_to_reg_val;
      reg_to_dc_rs1_rob_index = '0;
    end
  end

  always_comb begin
    reg_to_dc_rs2_val       = val_q[dc_to_reg_rs2];
    reg_to_dc_rs2_rob_index = tag_q[dc_to_reg_rs2];
    if (dc_to_reg_rs2 == '0) begin
      reg_to_dc_rs2_val       = '0;
      reg_to_dc_rs2_rob_index = '0;
    end else if (rs2_byp) begin
      reg_to_dc_rs2_val       = rob_to_reg_val;
      reg_to_dc_rs2_rob_index = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file
// Directed scenarios followed by randomized traffic against an array-based reference model.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic        clr_in = 1'b0;
  logic        rob_to_reg_commit = 1'b0;
  logic [3:0]  rob_to_reg_rob_index = '0;
  logic [4:0]  rob_to_reg_index = '0;
  logic [31:0] rob_to_reg_val = '0;
  logic        dc_to_reg_rename = 1'b0;
  logic [4:0]  dc_to_reg_rd = '0;
  logic [3:0]  dc_to_reg_rob_index = '0;
  logic [4:0]  dc_to_reg_rs1 = '0;
  logic [4:0]  dc_to_reg_rs2 = '0;
  logic [31:0] reg_to_dc_rs1_val;
  logic [3:0]  reg_to_dc_rs1_rob_index;
  logic [31:0] reg_to_dc_rs2_val;
  logic [3:0]  reg_to_dc_rs2_rob_index;

  reg_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .rob_to_reg_commit(rob_to_reg_commit), .rob_to_reg_rob_index(rob_to_reg_rob_index),
    .rob_to_reg_index(rob_to_reg_index), .rob_to_reg_val(rob_to_reg_val),
    .dc_to_reg_rename(dc_to_reg_rename), .dc_to_reg_rd(dc_to_reg_rd),
    .dc_to_reg_rob_index(dc_to_reg_rob_index),
    .dc_to_reg_rs1(dc_to_reg_rs1), .dc_to_reg_rs2(dc_to_reg_rs2),
    .reg_to_dc_rs1_val(reg_to_dc_rs1_val), .reg_to_dc_rs1_rob_index(reg_to_dc_rs1_rob_index),
    .reg_to_dc_rs2_val(reg_to_dc_rs2_val), .reg_to_dc_rs2_rob_index(reg_to_dc_rs2_rob_index)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic [31:0] v2;
    logic [3:0]  t2;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mval [32];
  logic [3:0]  mtag [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  always @(negedge clk_in) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".rs1_val"}, reg_to_dc_rs1_val, e.v1);
      chk({e.name, ".rs1_tag"}, {28'd0, reg_to_dc_rs1_rob_index}, {28'd0, e.t1});
      chk({e.name, ".rs2_val"}, reg_to_dc_rs2_val, e.v2);
      chk({e.name, ".rs2_tag"}, {28'd0, reg_to_dc_rs2_rob_index}, {28'd0, e.t2});
    end
  end

  // Reference view of a read: x0 is zero, a matching commit forwards, else stored state.
  task automatic model_read(input logic [4:0] rs, input bit commit, input logic [3:0] cidx,
                            input logic [4:0] crd, input logic [31:0] cval,
                            output logic [31:0] v, output logic [3:0] t);
    if (rs == 0) begin
      v = 0; t = 0;
    end else if (commit && crd == rs && mtag[rs] == cidx) begin
      v = cval; t = 0;
    end else begin
      v = mval[rs]; t = mtag[rs];
    end
  endtask

  task automatic cyc(input string nm, input bit rdy, input bit clr,
                     input bit commit, input logic [3:0] cidx, input logic [4:0] crd,
                     input logic [31:0] cval,
                     input bit ren, input logic [4:0] rrd, input logic [3:0] ridx,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t       e;
    logic [3:0] old_tag;
    @(posedge clk_in);
    #1;
    rdy_in = rdy; clr_in = clr;
    rob_to_reg_commit = commit; rob_to_reg_rob_index = cidx;
    rob_to_reg_index = crd; rob_to_reg_val = cval;
    dc_to_reg_rename = ren; dc_to_reg_rd = rrd; dc_to_reg_rob_index = ridx;
    dc_to_reg_rs1 = rs1; dc_to_reg_rs2 = rs2;
    e.name = nm;
    model_read(rs1, commit, cidx, crd, cval, e.v1, e.t1);
    model_read(rs2, commit, cidx, crd, cval, e.v2, e.t2);
    exp_q.push_back(e);
    if (rdy) begin
      old_tag = mtag[crd];
      if (commit && crd != 0) begin
        mval[crd] = cval;
        if (old_tag == cidx) mtag[crd] = 0;
      end
      if (clr) begin
        for (int i = 0; i < 32; i++) mtag[i] = 0;
      end else if (ren && rrd != 0) begin
        mtag[rrd] = ridx;
      end
    end
  endtask

  task automatic rd(input string nm, input logic [4:0] rs1, input logic [4:0] rs2);
    cyc(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, rs1, rs2);
  endtask

  task automatic ren(input string nm, input logic [4:0] r, input logic [3:0] t);
    cyc(nm, 1, 0, 0, 0, 0, 0, 1, r, t, 0, 0);
  endtask

  // Reset is raised mid-cycle and checked at the following falling edge, before any rising edge.
  task automatic reset_check(input string nm, input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t e;
    @(posedge clk_in);
    #1;
    rst_in = 1; rdy_in = 1; clr_in = 0;
    rob_to_reg_commit = 0; dc_to_reg_rename = 0;
    dc_to_reg_rs1 = rs1; dc_to_reg_rs2 = rs2;
    for (int i = 0; i < 32; i++) begin
      mval[i] = 0; mtag[i] = 0;
    end
    e.name = nm; e.v1 = 0; e.t1 = 0; e.v2 = 0; e.t2 = 0;
    exp_q.push_back(e);
    @(negedge clk_in);
    #1;
    rst_in = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mval[i] = 0; mtag[i] = 0;
    end
    reset_check("reset", 5, 0);

    ren("ren_x3", 3, 2);
    rd("rd_x3_tag", 3, 0);
    cyc("commit_byp", 1, 0, 1, 2, 3, 32'hDEADBEEF, 0, 0, 0, 3, 3);
    rd("rd_x3_after", 3, 0);

    ren("ren_x4_1", 4, 1);
    ren("ren_x4_5", 4, 5);
    cyc("stale_commit", 1, 0, 1, 1, 4, 32'd7, 0, 0, 0, 4, 0);
    rd("rd_x4", 4, 3);

    ren("ren_x6_2", 6, 2);
    cyc("commit_ren_x6", 1, 0, 1, 2, 6, 32'h66, 1, 6, 3, 6, 0);
    cyc("ren_x0", 1, 0, 0, 0, 0, 0, 1, 0, 9, 6, 0);
    rd("rd_x6_x0", 6, 0);

    ren("ren_x1", 1, 4);
    ren("ren_x2", 2, 6);
    ren("ren_x7", 7, 8);
    cyc("clr_commit", 1, 1, 1, 4, 1, 32'd9, 1, 8, 10, 1, 2);
    rd("rd_after_clr_a", 1, 8);
    rd("rd_after_clr_b", 2, 7);

    cyc("rdy_low", 0, 0, 1, 0, 5, 32'h55, 1, 9, 11, 9, 5);
    rd("rd_rdy_low", 9, 5);
    cyc("rdy_high", 1, 0, 1, 0, 5, 32'h55, 1, 9, 11, 9, 5);
    rd("rd_rdy_high", 9, 5);

    ren("ren_x3_again", 3, 2);
    rd("rd_x3_pre_rst", 3, 0);
    reset_check("reset_mid", 3, 6);

    for (int n = 0; n < 400; n++) begin
      bit          r_rdy, r_clr, r_com, r_ren;
      logic [4:0]  r_crd, r_rrd, r_rs1, r_rs2;
      logic [3:0]  r_cidx, r_ridx;
      logic [31:0] r_cval;
      r_rdy  = ($urandom_range(9) != 0);
      r_clr  = ($urandom_range(19) == 0);
      r_com  = $urandom_range(1);
      r_ren  = ($urandom_range(2) != 0);
      r_crd  = 5'($urandom_range(31));
      r_cidx = ($urandom_range(2) != 0) ? mtag[r_crd] : 4'($urandom_range(1, 15));
      r_cval = $urandom;
      r_rrd  = 5'($urandom_range(31));
      r_ridx = 4'($urandom_range(1, 15));
      r_rs1  = ($urandom_range(2) == 0) ? r_crd : 5'($urandom_range(31));
      r_rs2  = ($urandom_range(3) == 0) ? r_rrd : 5'($urandom_range(31));
      cyc("rand", r_rdy, r_clr, r_com, r_cidx, r_crd, r_cval, r_ren, r_rrd, r_ridx, r_rs1, r_rs2);
    end

    repeat (3) @(posedge clk_in);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
